// File: rtl/i2s_tx_10xe_axis_chan_sched.sv
// Frame scheduler for the I2S TX audio AXI-Stream port.
// Each frame visits every channel enabled in the latched mask in ascending order,
// forwards one sample per channel tagged with its index, and substitutes a zero
// sample when a source stalls too long, so that the I2S slots stay aligned.
module i2s_tx_10xe_axis_chan_sched #(
    parameter int NUM_CH      = 8,
    parameter int DATA_W      = 32,
    parameter int UNDERRUN_TO = 64
) (
    input  logic                     s_axis_aud_aclk,
    input  logic                     s_axis_aud_aresetn,
    input  logic                     enable,
    input  logic [NUM_CH-1:0]        ch_mask,
    input  logic [NUM_CH*DATA_W-1:0] ch_tdata,
    input  logic [NUM_CH-1:0]        ch_tvalid,
    output logic [NUM_CH-1:0]        ch_tready,
    output logic [DATA_W-1:0]        s_axis_aud_tdata,
    output logic [2:0]               s_axis_aud_tid,
    output logic                     s_axis_aud_tvalid,
    input  logic                     s_axis_aud_tready,
    output logic                     frame_done,
    output logic                     underrun,
    output logic [15:0]              underrun_cnt
);

    localparam int                  WAIT_W  = 16;
    localparam bit                  TO_EN   = (UNDERRUN_TO != 0);
    localparam logic [WAIT_W-1:0]   TO_LAST = WAIT_W'((UNDERRUN_TO == 0) ? 0 : UNDERRUN_TO - 1);

    typedef enum logic [0:0] {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [NUM_CH-1:0]   fmask;
    logic [NUM_CH-1:0]   fmask_nxt;
    logic [2:0]          cur;
    logic [2:0]          cur_nxt;
    logic [WAIT_W-1:0]   wait_cnt;

    logic                sel_valid;
    logic [DATA_W-1:0]   sel_data;
    logic                slot_free;
    logic                timeout;
    logic [3:0]          above;
    logic                accept;
    logic                fill;
    logic                load;
    logic                last;

    // output register stage
    logic                vld_p1;
    logic [DATA_W-1:0]   data_p1;
    logic [2:0]          tid_p1;

    // Lowest set bit of a mask (0 when the mask is empty).
    function automatic logic [2:0] lowest(input logic [NUM_CH-1:0] m);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i]) r = i[2:0];
        end
        return r;
    endfunction

    // {found, index} of the next set bit strictly above position c.
    function automatic logic [3:0] next_above(input logic [NUM_CH-1:0] m, input logic [2:0] c);
        logic [3:0] r;
        r = 4'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) r = {1'b1, i[2:0]};
        end
        return r;
    endfunction

    // Saturating increment for the underrun counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Select the current channel's valid and sample.
    always_comb begin
        sel_valid = 1'b0;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (i[2:0] == cur) begin
                sel_valid = ch_tvalid[i];
                sel_data  = ch_tdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign slot_free = !vld_p1 || s_axis_aud_tready;
    assign timeout   = TO_EN && (state == ST_RUN) && (wait_cnt == TO_LAST) && slot_free;
    assign above     = next_above(fmask, cur);

    // Next-state, channel handshake and load decision.
    always_comb begin
        state_nxt = state;
        fmask_nxt = fmask;
        cur_nxt   = cur;
        ch_tready = '0;
        accept    = 1'b0;
        fill      = 1'b0;
        load      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && (ch_mask != '0)) begin
                    fmask_nxt = ch_mask;
                    cur_nxt   = lowest(ch_mask);
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A timeout pre-empts the source, even one that just became valid.
                fill   = timeout;
                accept = slot_free && sel_valid && !timeout;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (i[2:0] == cur) ch_tready[i] = slot_free && !timeout;
                end
                load = accept || fill;
                if (load) begin
                    if (above[3]) begin
                        cur_nxt = above[2:0];
                    end else begin
                        last = 1'b1;
                        if (enable && (ch_mask != '0)) begin
                            fmask_nxt = ch_mask;
                            cur_nxt   = lowest(ch_mask);
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // FSM state, latched frame mask and current channel.
    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            state <= ST_IDLE;
            fmask <= '0;
            cur   <= 3'd0;
        end else begin
            state <= state_nxt;
            fmask <= fmask_nxt;
            cur   <= cur_nxt;
        end
    end

    // Wait counter: cycles the free slot spends waiting on the current source.
    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            wait_cnt <= '0;
        end else if (load || (state != ST_RUN)) begin
            wait_cnt <= '0;
        end else if (slot_free && !sel_valid && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Output register: a new load wins over a concurrent consume.
    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            tid_p1  <= 3'd0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            data_p1 <= fill ? '0 : sel_data;
            tid_p1  <= cur;
        end else if (s_axis_aud_tready) begin
            vld_p1  <= 1'b0;
        end
    end

    // Status pulses and the saturating underrun count.
    always_ff @(posedge s_axis_aud_aclk) begin
        if (!s_axis_aud_aresetn) begin
            frame_done   <= 1'b0;
            underrun     <= 1'b0;
            underrun_cnt <= 16'd0;
        end else begin
            frame_done <= load && last;
            underrun   <= fill;
            if (fill) underrun_cnt <= sat_inc(underrun_cnt);
        end
    end

    assign s_axis_aud_tvalid = vld_p1;
    assign s_axis_aud_tdata  = data_p1;
    assign s_axis_aud_tid    = tid_p1;

endmodule

// File: tb/tb_i2s_tx_10xe_axis_chan_sched.sv
// Directed bench for the I2S TX channel scheduler (8 channels, underrun timeout 4).
module tb_i2s_tx_10xe_axis_chan_sched;

    localparam int NUM_CH = 8;
    localparam int DATA_W = 32;

    logic                     clk;
    logic                     aresetn;
    logic                     enable;
    logic [NUM_CH-1:0]        ch_mask;
    logic [NUM_CH*DATA_W-1:0] ch_tdata;
    logic [NUM_CH-1:0]        ch_tvalid;
    logic [NUM_CH-1:0]        ch_tready;
    logic [DATA_W-1:0]        s_tdata;
    logic [2:0]               s_tid;
    logic                     s_tvalid;
    logic                     s_tready;
    logic                     frame_done;
    logic                     underrun;
    logic [15:0]              underrun_cnt;

    int total = 0;
    int bad   = 0;

    i2s_tx_10xe_axis_chan_sched #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .UNDERRUN_TO(4)
    ) dut (
        .s_axis_aud_aclk   (clk),
        .s_axis_aud_aresetn(aresetn),
        .enable            (enable),
        .ch_mask           (ch_mask),
        .ch_tdata          (ch_tdata),
        .ch_tvalid         (ch_tvalid),
        .ch_tready         (ch_tready),
        .s_axis_aud_tdata  (s_tdata),
        .s_axis_aud_tid    (s_tid),
        .s_axis_aud_tvalid (s_tvalid),
        .s_axis_aud_tready (s_tready),
        .frame_done        (frame_done),
        .underrun          (underrun),
        .underrun_cnt      (underrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Fixed sample value offered by channel i.
    function automatic logic [31:0] dv(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        aresetn = 1'b0; enable = 1'b0; ch_mask = '0; ch_tvalid = '0; s_tready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step;
            total++;
            if ({s_tvalid, ch_tready, underrun_cnt, frame_done, underrun, s_tdata, s_tid} !== '0) begin
                bad++;
                $display("FAIL reset k=%0d got tv=%0b rdy=%h cnt=%0d fd=%0b ur=%0b data=%h tid=%0d exp all 0",
                         k, s_tvalid, ch_tready, underrun_cnt, frame_done, underrun, s_tdata, s_tid);
            end
        end
        aresetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step;
            total++;
            if ({s_tvalid, ch_tready, underrun_cnt} !== '0) begin
                bad++;
                $display("FAIL idle k=%0d got tv=%0b rdy=%h cnt=%0d exp 0 0 0", k, s_tvalid, ch_tready, underrun_cnt);
            end
        end
    endtask

    task automatic test_two_ch;
        logic [2:0] etid;
        logic       efd;
        logic [7:0] erdy;
        ch_mask = 8'h05; ch_tvalid = 8'hFF; s_tready = 1'b1; enable = 1'b1;
        step;
        total++;
        if (ch_tready !== 8'h01) begin
            bad++;
            $display("FAIL two_ch first_ready got=%h exp=01", ch_tready);
        end
        for (int k = 0; k < 8; k++) begin
            step;
            etid = (k % 2 == 1) ? 3'd2 : 3'd0;
            efd  = (k % 2 == 1);
            erdy = (k % 2 == 1) ? 8'h01 : 8'h04;
            total++;
            if ({s_tvalid, s_tid, s_tdata, frame_done, underrun, ch_tready} !==
                {1'b1, etid, dv(int'(etid)), efd, 1'b0, erdy}) begin
                bad++;
                $display("FAIL two_ch beat k=%0d got tv=%0b tid=%0d data=%h fd=%0b ur=%0b rdy=%h exp tv=1 tid=%0d data=%h fd=%0b ur=0 rdy=%h",
                         k, s_tvalid, s_tid, s_tdata, frame_done, underrun, ch_tready, etid, dv(int'(etid)), efd, erdy);
            end
        end
        enable = 1'b0;
        repeat (6) step;
        total++;
        if ({s_tvalid, ch_tready} !== 9'd0) begin
            bad++;
            $display("FAIL two_ch drain got tv=%0b rdy=%h exp 0 00", s_tvalid, ch_tready);
        end
    endtask

    task automatic test_back_pressure;
        ch_mask = 8'h03; ch_tvalid = 8'hFF; s_tready = 1'b0; enable = 1'b1;
        step;
        total++;
        if (ch_tready !== 8'h01) begin
            bad++;
            $display("FAIL bp first_ready got=%h exp=01", ch_tready);
        end
        step;
        for (int h = 0; h < 5; h++) begin
            total++;
            if ({s_tvalid, s_tid, s_tdata, ch_tready} !== {1'b1, 3'd0, dv(0), 8'h00}) begin
                bad++;
                $display("FAIL bp hold h=%0d got tv=%0b tid=%0d data=%h rdy=%h exp tv=1 tid=0 data=%h rdy=00",
                         h, s_tvalid, s_tid, s_tdata, ch_tready, dv(0));
            end
            if (h < 4) step;
        end
        s_tready = 1'b1; enable = 1'b0;
        #1;
        total++;
        if (ch_tready !== 8'h02) begin
            bad++;
            $display("FAIL bp release_ready got=%h exp=02", ch_tready);
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, frame_done} !== {1'b1, 3'd1, dv(1), 1'b1}) begin
            bad++;
            $display("FAIL bp ch1_beat got tv=%0b tid=%0d data=%h fd=%0b exp 1 1 %h 1", s_tvalid, s_tid, s_tdata, frame_done, dv(1));
        end
        step;
        total++;
        if ({s_tvalid, ch_tready} !== 9'd0) begin
            bad++;
            $display("FAIL bp drain got tv=%0b rdy=%h exp 0 00", s_tvalid, ch_tready);
        end
    endtask

    task automatic test_underrun;
        ch_mask = 8'h03; ch_tvalid = 8'h01; s_tready = 1'b1; enable = 1'b1;
        step;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, underrun} !== {1'b1, 3'd0, dv(0), 1'b0}) begin
            bad++;
            $display("FAIL ur ch0_beat got tv=%0b tid=%0d data=%h ur=%0b exp 1 0 %h 0", s_tvalid, s_tid, s_tdata, underrun, dv(0));
        end
        step;
        total++;
        if ({ch_tready, s_tvalid, underrun_cnt} !== {8'h02, 1'b0, 16'd0}) begin
            bad++;
            $display("FAIL ur wait1 got rdy=%h tv=%0b cnt=%0d exp 02 0 0", ch_tready, s_tvalid, underrun_cnt);
        end
        step;
        total++;
        if (ch_tready !== 8'h02) begin
            bad++;
            $display("FAIL ur wait2 got rdy=%h exp=02", ch_tready);
        end
        step;
        total++;
        if (ch_tready !== 8'h00) begin
            bad++;
            $display("FAIL ur timeout_ready got rdy=%h exp=00", ch_tready);
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, underrun, frame_done, underrun_cnt} !== {1'b1, 3'd1, 32'd0, 1'b1, 1'b1, 16'd1}) begin
            bad++;
            $display("FAIL ur fill1 got tv=%0b tid=%0d data=%h ur=%0b fd=%0b cnt=%0d exp 1 1 0 1 1 1",
                     s_tvalid, s_tid, s_tdata, underrun, frame_done, underrun_cnt);
        end
        step;
        total++;
        if ({s_tvalid, s_tid, underrun, underrun_cnt} !== {1'b1, 3'd0, 1'b0, 16'd1}) begin
            bad++;
            $display("FAIL ur frame2_ch0 got tv=%0b tid=%0d ur=%0b cnt=%0d exp 1 0 0 1", s_tvalid, s_tid, underrun, underrun_cnt);
        end
        step;
        step;
        step;
        ch_tvalid = 8'h03;
        #1;
        total++;
        if (ch_tready !== 8'h00) begin
            bad++;
            $display("FAIL ur late_valid_ready got rdy=%h exp=00", ch_tready);
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, underrun, underrun_cnt} !== {1'b1, 3'd1, 32'd0, 1'b1, 16'd2}) begin
            bad++;
            $display("FAIL ur fill2 got tv=%0b tid=%0d data=%h ur=%0b cnt=%0d exp 1 1 0 1 2",
                     s_tvalid, s_tid, s_tdata, underrun, underrun_cnt);
        end
        enable = 1'b0;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, underrun} !== {1'b1, 3'd0, dv(0), 1'b0}) begin
            bad++;
            $display("FAIL ur frame3_ch0 got tv=%0b tid=%0d data=%h ur=%0b exp 1 0 %h 0", s_tvalid, s_tid, s_tdata, underrun, dv(0));
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, frame_done, underrun, underrun_cnt} !== {1'b1, 3'd1, dv(1), 1'b1, 1'b0, 16'd2}) begin
            bad++;
            $display("FAIL ur frame3_ch1 got tv=%0b tid=%0d data=%h fd=%0b ur=%0b cnt=%0d exp 1 1 %h 1 0 2",
                     s_tvalid, s_tid, s_tdata, frame_done, underrun, underrun_cnt, dv(1));
        end
        step;
        total++;
        if ({s_tvalid, ch_tready, underrun_cnt} !== {1'b0, 8'h00, 16'd2}) begin
            bad++;
            $display("FAIL ur drain got tv=%0b rdy=%h cnt=%0d exp 0 00 2", s_tvalid, ch_tready, underrun_cnt);
        end
    endtask

    task automatic test_enable_drop;
        ch_mask = 8'h07; ch_tvalid = 8'hFF; s_tready = 1'b1; enable = 1'b1;
        step;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata} !== {1'b1, 3'd0, dv(0)}) begin
            bad++;
            $display("FAIL drop ch0 got tv=%0b tid=%0d data=%h exp 1 0 %h", s_tvalid, s_tid, s_tdata, dv(0));
        end
        enable = 1'b0; ch_mask = 8'h01;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, frame_done} !== {1'b1, 3'd1, dv(1), 1'b0}) begin
            bad++;
            $display("FAIL drop ch1 got tv=%0b tid=%0d data=%h fd=%0b exp 1 1 %h 0", s_tvalid, s_tid, s_tdata, frame_done, dv(1));
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, frame_done, ch_tready} !== {1'b1, 3'd2, dv(2), 1'b1, 8'h00}) begin
            bad++;
            $display("FAIL drop ch2 got tv=%0b tid=%0d data=%h fd=%0b rdy=%h exp 1 2 %h 1 00",
                     s_tvalid, s_tid, s_tdata, frame_done, ch_tready, dv(2));
        end
        for (int k = 0; k < 2; k++) begin
            step;
            total++;
            if ({s_tvalid, ch_tready, frame_done} !== 10'd0) begin
                bad++;
                $display("FAIL drop idle k=%0d got tv=%0b rdy=%h fd=%0b exp 0 00 0", k, s_tvalid, ch_tready, frame_done);
            end
        end
    endtask

    task automatic test_single_channel;
        ch_mask = 8'h10; ch_tvalid = 8'hFF; s_tready = 1'b1; enable = 1'b1;
        step;
        for (int k = 0; k < 3; k++) begin
            step;
            total++;
            if ({s_tvalid, s_tid, s_tdata, frame_done} !== {1'b1, 3'd4, dv(4), 1'b1}) begin
                bad++;
                $display("FAIL single k=%0d got tv=%0b tid=%0d data=%h fd=%0b exp 1 4 %h 1",
                         k, s_tvalid, s_tid, s_tdata, frame_done, dv(4));
            end
        end
        enable = 1'b0;
        repeat (3) step;
        total++;
        if ({s_tvalid, ch_tready} !== 9'd0) begin
            bad++;
            $display("FAIL single drain got tv=%0b rdy=%h exp 0 00", s_tvalid, ch_tready);
        end
    endtask

    task automatic test_reset_midframe;
        ch_mask = 8'h06; ch_tvalid = 8'hFF; s_tready = 1'b0; enable = 1'b1;
        step;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, underrun_cnt} !== {1'b1, 3'd1, dv(1), 16'd2}) begin
            bad++;
            $display("FAIL rstmid pre got tv=%0b tid=%0d data=%h cnt=%0d exp 1 1 %h 2", s_tvalid, s_tid, s_tdata, underrun_cnt, dv(1));
        end
        aresetn = 1'b0;
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, ch_tready, underrun_cnt, frame_done, underrun} !== '0) begin
            bad++;
            $display("FAIL rstmid cleared got tv=%0b tid=%0d data=%h rdy=%h cnt=%0d fd=%0b ur=%0b exp all 0",
                     s_tvalid, s_tid, s_tdata, ch_tready, underrun_cnt, frame_done, underrun);
        end
        aresetn = 1'b1; s_tready = 1'b1;
        step;
        total++;
        if (ch_tready !== 8'h02) begin
            bad++;
            $display("FAIL rstmid restart_ready got=%h exp=02", ch_tready);
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata} !== {1'b1, 3'd1, dv(1)}) begin
            bad++;
            $display("FAIL rstmid ch1 got tv=%0b tid=%0d data=%h exp 1 1 %h", s_tvalid, s_tid, s_tdata, dv(1));
        end
        step;
        total++;
        if ({s_tvalid, s_tid, s_tdata, frame_done} !== {1'b1, 3'd2, dv(2), 1'b1}) begin
            bad++;
            $display("FAIL rstmid ch2 got tv=%0b tid=%0d data=%h fd=%0b exp 1 2 %h 1", s_tvalid, s_tid, s_tdata, frame_done, dv(2));
        end
        enable = 1'b0;
        repeat (4) step;
        total++;
        if ({s_tvalid, ch_tready} !== 9'd0) begin
            bad++;
            $display("FAIL rstmid drain got tv=%0b rdy=%h exp 0 00", s_tvalid, ch_tready);
        end
    endtask

    initial begin
        for (int i = 0; i < NUM_CH; i++) ch_tdata[i*DATA_W +: DATA_W] = dv(i);
        test_reset;
        test_two_ch;
        test_back_pressure;
        test_underrun;
        test_enable_drop;
        test_single_channel;
        test_reset_midframe;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
